// File: rtl/avalon_ram_slave_if.sv
// Avalon-MM bus bundle between a CPU-side master and the RAM slave.
// The master drives the request fields. The slave drives the response fields.
interface avalon_ram_slave_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        waitrequest;
   logic        err;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, waitrequest, err
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, waitrequest, err
   );
endinterface

// File: rtl/avalon_ram_slave.sv
// Avalon-MM word RAM slave with byte-enable writes, programmable waitrequest latency and protocol checking.
// Optional MEM_RANDOM_WAIT_EN adds 0..3 LFSR-driven extra wait cycles per transfer. RAM powers up X; images are loaded by bus writes.
module avalon_ram_slave #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
`ifdef MEM_RANDOM_WAIT_EN
   , parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
   input logic               clk,
   input logic               reset,
   avalon_ram_slave_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;
   localparam int DEPTH = 1 << ADDR_W;

   state_e            state_q;
   logic [4:0]        cnt_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic [3:0]        be_q;
   logic              rd_q, wr_q;
   logic              bad_q;       // latched request is a no-op (illegal op or misaligned)
   logic              chg_seen_q;  // a mid-wait change was already flagged this transfer
   logic              err_q;
   logic [31:0]       mem [DEPTH];

   logic              req;
   logic              req_bad;
   logic              changed;
   logic              commit;
   logic [4:0]        load_cnt;
   logic [ADDR_W-1:0] idx_in;
   logic [ADDR_W-1:0] idx_q;

   assign req     = bus.read | bus.write;
   assign req_bad = (bus.read & bus.write) | (bus.address[1:0] != 2'b00);
   assign idx_in  = bus.address[ADDR_W+1:2];
   assign idx_q   = addr_q[ADDR_W+1:2];
   assign changed = (bus.address != addr_q) || (bus.read != rd_q) || (bus.write != wr_q) ||
                    (bus.writedata != wdata_q) || (bus.byteenable != be_q);
   // A reset landing on the ACK edge must still drop the pending write.
   assign commit  = (state_q == S_ACK) && wr_q && !bad_q && !reset;

`ifdef MEM_RANDOM_WAIT_EN
   localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   logic [7:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= SEED_EFF;
      end else if (state_q == S_IDLE && req) begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign load_cnt = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
`else
   assign load_cnt = 5'(WAIT_CYCLES);
`endif

   // cnt_q counts the WAIT cycles still to go, including the current one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         bad_q      <= 1'b0;
         chg_seen_q <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  addr_q     <= bus.address;
                  wdata_q    <= bus.writedata;
                  be_q       <= bus.byteenable;
                  rd_q       <= bus.read;
                  wr_q       <= bus.write;
                  bad_q      <= req_bad;
                  err_q      <= req_bad;
                  chg_seen_q <= 1'b0;
                  cnt_q      <= load_cnt;
                  if (load_cnt == 5'd0) begin
                     state_q <= S_ACK;
                     rdata_q <= (bus.read && !req_bad) ? mem[idx_in] : '0;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 5'd1;
               if (changed && !chg_seen_q) begin
                  err_q      <= 1'b1;
                  chg_seen_q <= 1'b1;
               end
               if (cnt_q == 5'd1) begin
                  state_q <= S_ACK;
                  rdata_q <= (rd_q && !bad_q) ? mem[idx_q] : '0;
               end
            end
            S_ACK:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // NOTE: the RAM array has no reset; contents must survive reset and a reset port would block RAM inference.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign bus.readdata    = rdata_q;
   assign bus.err         = err_q;
   assign bus.waitrequest = (state_q == S_IDLE) ? req : (state_q == S_WAIT);

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Self-checking bench for avalon_ram_slave: two instances (WAIT_CYCLES=2 and 0) checked against a word-level memory model.
// Builds with or without MEM_RANDOM_WAIT_EN; latency expectations widen to +0..3 cycles when it is defined.
module tb_avalon_ram_slave;
   localparam int D2 = 0;  // instance with WAIT_CYCLES=2
   localparam int D0 = 1;  // instance with WAIT_CYCLES=0

   logic        clk = 1'b0;
   logic        reset;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] mdl [int];

   avalon_ram_slave_if if2 ();
   avalon_ram_slave_if if0 ();

   avalon_ram_slave #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
   avalon_ram_slave #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      if (sel == D2) begin
         if2.read = rd; if2.write = wr; if2.address = a; if2.writedata = d; if2.byteenable = be;
      end else begin
         if0.read = rd; if0.write = wr; if0.address = a; if0.writedata = d; if0.byteenable = be;
      end
   endtask

   function automatic logic get_wait(input int sel);
      return (sel == D2) ? if2.waitrequest : if0.waitrequest;
   endfunction

   function automatic logic get_err(input int sel);
      return (sel == D2) ? if2.err : if0.err;
   endfunction

   function automatic logic [31:0] get_rdata(input int sel);
      return (sel == D2) ? if2.readdata : if0.readdata;
   endfunction

   // Latency = index of the cycle in which waitrequest first drops (request presented in cycle 0).
   function automatic bit lat_ok(input int sel, input int lat);
      int w;
      w = (sel == D2) ? 2 : 0;
`ifdef MEM_RANDOM_WAIT_EN
      return (lat >= w + 1) && (lat <= w + 4);
`else
      return lat == w + 1;
`endif
   endfunction

   function automatic int key(input int sel, input logic [31:0] a);
      return sel * 4096 + int'(a[11:2]);
   endfunction

   task automatic model_wr(input int sel, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      w = mdl.exists(key(sel, a)) ? mdl[key(sel, a)] : 32'hxxxx_xxxx;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[key(sel, a)] = w;
   endtask

   // One complete bus transfer; optionally swaps the address in cycle chg_cyc to model a misbehaving master.
   task automatic xfer(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input int chg_cyc, input logic [31:0] chg_a,
                       output logic [31:0] rdata, output int lat, output bit err_seen, output int ack_cyc);
      bit done;
      done = 1'b0; err_seen = 1'b0; lat = -1; rdata = '0; ack_cyc = -1;
      drive(sel, rd, wr, a, d, be);
      for (int i = 0; i < 40 && !done; i++) begin
         if (i > 0 && i == chg_cyc) drive(sel, rd, wr, chg_a, d, be);
         @(negedge clk);
         if (get_err(sel) === 1'b1) err_seen = 1'b1;
         if (get_wait(sel) === 1'b0) begin
            done = 1'b1; lat = i; rdata = get_rdata(sel); ack_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      drive(sel, 1'b0, 1'b0, '0, '0, '0);
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL xfer_timeout sel=%0d addr=%h: no ACK within 40 cycles", sel, a);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(D2, 1'b0, 1'b0, '0, '0, '0);
      drive(D0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_checks++;
         if (get_wait(s) !== 1'b0) begin n_fail++; $display("FAIL reset_wait sel=%0d got=%b exp=0", s, get_wait(s)); end
         n_checks++;
         if (get_rdata(s) !== 32'h0) begin n_fail++; $display("FAIL reset_rdata sel=%0d got=%h exp=0", s, get_rdata(s)); end
         n_checks++;
         if (get_err(s) !== 1'b0) begin n_fail++; $display("FAIL reset_err sel=%0d got=%b exp=0", s, get_err(s)); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      logic [31:0] r; int lat, ac; bit e;
      xfer(D2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, '0, r, lat, e, ac);
      model_wr(D2, 32'h10, 32'hDEADBEEF, 4'hF);
      n_checks++;
      if (!lat_ok(D2, lat)) begin n_fail++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      n_checks++;
      if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%b exp=0", e); end
      xfer(D2, 1'b1, 1'b0, 32'h10, '0, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (!lat_ok(D2, lat)) begin n_fail++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      n_checks++;
      if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", r); end
   endtask

   task automatic test_byte_enable();
      logic [31:0] r; int lat, ac; bit e;
      xfer(D2, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, '0, r, lat, e, ac);
      model_wr(D2, 32'h20, 32'h11223344, 4'hF);
      xfer(D2, 1'b0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0, '0, r, lat, e, ac);
      model_wr(D2, 32'h20, 32'h0000AA00, 4'b0010);
      xfer(D2, 1'b1, 1'b0, 32'h20, '0, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (r !== 32'h1122AA44) begin n_fail++; $display("FAIL be_lane1 got=%h exp=1122aa44", r); end
      xfer(D2, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, '0, r, lat, e, ac);
      n_checks++;
      if (!lat_ok(D2, lat) || e !== 1'b0) begin n_fail++; $display("FAIL be_zero_ack lat=%0d err=%b exp lat=3 err=0", lat, e); end
      // 0xBFC00020 aliases to word 8 once the upper address bits are dropped.
      xfer(D2, 1'b1, 1'b0, 32'hBFC00020, '0, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (r !== mdl[key(D2, 32'h20)]) begin n_fail++; $display("FAIL be_zero_alias got=%h exp=%h", r, mdl[key(D2, 32'h20)]); end
   endtask

   task automatic test_errors();
      logic [31:0] r; int lat, ac; bit e;
      xfer(D2, 1'b0, 1'b1, 32'h30, 32'h55, 4'hF, 0, '0, r, lat, e, ac);
      model_wr(D2, 32'h30, 32'h55, 4'hF);
      xfer(D2, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (e !== 1'b1) begin n_fail++; $display("FAIL rw_both_err got=%b exp=1", e); end
      n_checks++;
      if (!lat_ok(D2, lat) || r !== 32'h0) begin n_fail++; $display("FAIL rw_both_ack lat=%0d rdata=%h exp lat=3 rdata=0", lat, r); end
      xfer(D2, 1'b0, 1'b1, 32'h32, 32'hFFFFFFFF, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (e !== 1'b1) begin n_fail++; $display("FAIL misalign_wr_err got=%b exp=1", e); end
      xfer(D2, 1'b1, 1'b0, 32'h31, '0, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (e !== 1'b1 || r !== 32'h0) begin n_fail++; $display("FAIL misalign_rd err=%b rdata=%h exp err=1 rdata=0", e, r); end
      xfer(D2, 1'b1, 1'b0, 32'h30, '0, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (r !== 32'h55 || e !== 1'b0) begin n_fail++; $display("FAIL err_word_kept rdata=%h err=%b exp rdata=55 err=0", r, e); end
   endtask

   task automatic test_wait_change();
      logic [31:0] r; int lat, ac; bit e;
      xfer(D2, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, '0, r, lat, e, ac);
      model_wr(D2, 32'h40, 32'h12345678, 4'hF);
      xfer(D2, 1'b0, 1'b1, 32'h44, 32'h0BADF00D, 4'hF, 0, '0, r, lat, e, ac);
      model_wr(D2, 32'h44, 32'h0BADF00D, 4'hF);
      xfer(D2, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1, 32'h44, r, lat, e, ac);
      model_wr(D2, 32'h40, 32'hCAFEF00D, 4'hF);
      n_checks++;
      if (e !== 1'b1) begin n_fail++; $display("FAIL wait_change_err got=%b exp=1", e); end
      xfer(D2, 1'b1, 1'b0, 32'h40, '0, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (r !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wait_change_0x40 got=%h exp=cafef00d", r); end
      xfer(D2, 1'b1, 1'b0, 32'h44, '0, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (r !== 32'h0BADF00D) begin n_fail++; $display("FAIL wait_change_0x44 got=%h exp=0badf00d", r); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; int lat, ac; bit e;
      xfer(D2, 1'b0, 1'b1, 32'h50, 32'h600DCAFE, 4'hF, 0, '0, r, lat, e, ac);
      model_wr(D2, 32'h50, 32'h600DCAFE, 4'hF);
      drive(D2, 1'b0, 1'b1, 32'h50, 32'hFFFFFFFF, 4'hF);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(D2, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      n_checks++;
      if (get_wait(D2) !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_wait got=%b exp=1", get_wait(D2)); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (get_wait(D2) !== 1'b0 || get_err(D2) !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_idle wait=%b err=%b exp 0 0", get_wait(D2), get_err(D2));
      end
      @(posedge clk); #1;
      xfer(D2, 1'b1, 1'b0, 32'h50, '0, 4'hF, 0, '0, r, lat, e, ac);
      n_checks++;
      if (r !== 32'h600DCAFE) begin n_fail++; $display("FAIL rst_mid_word got=%h exp=600dcafe", r); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; int lat, ac; bit e;
      int acks [3];
      logic [31:0] d;
      for (int k = 0; k < 3; k++) begin
         d = $urandom;
         xfer(D0, 1'b0, 1'b1, 32'(4 * k), d, 4'hF, 0, '0, r, lat, e, ac);
         model_wr(D0, 32'(4 * k), d, 4'hF);
      end
      for (int k = 0; k < 3; k++) begin
         xfer(D0, 1'b1, 1'b0, 32'(4 * k), '0, 4'hF, 0, '0, r, lat, e, ac);
         acks[k] = ac;
         n_checks++;
         if (r !== mdl[key(D0, 32'(4 * k))]) begin
            n_fail++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, r, mdl[key(D0, 32'(4 * k))]);
         end
         n_checks++;
         if (!lat_ok(D0, lat)) begin n_fail++; $display("FAIL b2b_latency k=%0d got=%0d exp=1", k, lat); end
      end
`ifndef MEM_RANDOM_WAIT_EN
      for (int k = 1; k < 3; k++) begin
         n_checks++;
         if (acks[k] - acks[k-1] !== 2) begin
            n_fail++; $display("FAIL b2b_spacing k=%0d got=%0d exp=2", k, acks[k] - acks[k-1]);
         end
      end
`endif
   endtask

   task automatic test_random(input int sel, input int n_ops);
      logic [31:0] a, d, r; logic [3:0] be; int lat, ac; bit e, rd;
      for (int i = 0; i < n_ops; i++) begin
         a = $urandom;
         a[11:2] = 10'($urandom_range(64, 95));
         a[1:0] = 2'b00;
         rd = mdl.exists(key(sel, a)) && ($urandom_range(0, 1) == 1);
         if (rd) begin
            xfer(sel, 1'b1, 1'b0, a, '0, 4'hF, 0, '0, r, lat, e, ac);
            n_checks++;
            if (r !== mdl[key(sel, a)]) begin n_fail++; $display("FAIL rand_rd sel=%0d addr=%h got=%h exp=%h", sel, a, r, mdl[key(sel, a)]); end
         end else begin
            d = $urandom;
            be = mdl.exists(key(sel, a)) ? 4'($urandom) : 4'hF;
            xfer(sel, 1'b0, 1'b1, a, d, be, 0, '0, r, lat, e, ac);
            model_wr(sel, a, d, be);
         end
         n_checks++;
         if (!lat_ok(sel, lat) || e !== 1'b0) begin n_fail++; $display("FAIL rand_ack sel=%0d op=%0d lat=%0d err=%b", sel, i, lat, e); end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_byte_enable();
      test_errors();
      test_wait_change();
      test_reset_mid();
      test_back_to_back();
      test_random(D0, 100);
      test_random(D2, 40);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
